mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the 5-stage LoongArch pipeline; sits between EX and WB.
- Accepts the EX result bus and waits for the data-SRAM response of a load/store issued in EX.
- Aligns and sign/zero-extends load data, and forwards a 184-bit bus to WB.
- Exports a forwarding/stall bus to ID, an exception-pending flag to EX, and absorbs stale SRAM responses after a pipeline flush.

Parameters:
- None (all widths are fixed by the pipeline bus definitions in the shared package).

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
ex_mem_valid  in  1  EX holds a valid instruction
mem_allowin  out  1  MEM can accept from EX
ex_mem_bus  in  189  {res_from_mem, ld_type[2:0], mem_req_sent, payload[183:0]}
wb_allowin  in  1  WB can accept
mem_wb_valid  out  1  valid to WB
mem_wb_bus  out  184  {ertn, gr_we, pc, inst, final_result, dest, csr_we, csr_re, csr_num[13:0], csr_wmask, csr_wvalue, syscall}, MSB first
data_sram_data_ok  in  1  response strobe for the request issued in EX
data_sram_rdata  in  32  read data, valid with data_ok
mem_id_bus  out  40  {fwd_we, fwd_dest[4:0], fwd_data[31:0], ld_pending, csr_pending}
mem_ex  out  1  MEM holds syscall/ertn; EX must suppress its store request
flush  in  1  wb_ex | ertn_flush from WB

Behaviour:
- Reset:
  - mem_valid=0, discard=0, rbuf_valid=0.
  - All outputs derived from mem_valid, so mem_wb_valid=0, mem_ex=0, mem_id_bus fwd_we/ld_pending/csr_pending=0.
- Capture: when mem_allowin & ex_mem_valid, latch ex_mem_bus. mem_valid <= ex_mem_valid & ~flush when mem_allowin.
- Ready:
  - ready_go = ~mem_req_sent | data_ok_now | rbuf_valid.
  - data_ok_now = data_sram_data_ok & ~discard.
  - mem_allowin = ~mem_valid | (ready_go & wb_allowin).
  - mem_wb_valid = mem_valid & ready_go & ~flush.
- Response buffer: when data_ok_now arrives but wb_allowin=0, store rdata in rbuf and set rbuf_valid. Clear rbuf_valid on transfer to WB or on flush.
- Load data:
  - Addr[1:0] = final_result[1:0] of the latched payload.
  - ld_type encoding: 000 ld.w; 001 ld.b; 010 ld.h; 101 ld.bu; 110 ld.hu.
  - Byte is selected by addr[1:0]; half-word by addr[1] (addr[0] ignored).
  - Bit 2 of ld_type=1 zero-extends, else sign-extends.
  - When res_from_mem=1, final_result to WB = extended data; otherwise it is the ALU result unchanged.
- Discard FSM (IDLE/DISCARD):
  - IDLE->DISCARD when flush & mem_valid & mem_req_sent & ~data_sram_data_ok & ~rbuf_valid.
  - Also IDLE->DISCARD when flush coincides with EX issuing a request (ex_mem_valid & ex_mem_bus.mem_req_sent & mem_allowin).
  - DISCARD->IDLE on data_sram_data_ok; that response is dropped.
  - While in DISCARD, newly captured requests see no data_ok until the stale one has been swallowed.
  - A flush in the same cycle as the response drops it without entering DISCARD.
- Forwarding:
  - fwd_we = mem_valid & gr_we.
  - fwd_data = final result as sent to WB.
  - ld_pending = mem_valid & res_from_mem & ~ready_go; ID stalls on a dest match.
  - csr_pending = mem_valid & csr_re.
- mem_ex = mem_valid & (syscall | ertn).
- Reset mid-operation clears the FSM; no response is expected after reset.

Optional Feature:
- Macro: MEM_RDATA_BUF_EN.
- Defined: rbuf register present as described above.
- Undefined:
  - No rbuf; ready_go = ~mem_req_sent | data_ok_now.
  - The SRAM slave must hold data_ok/rdata until MEM transfers. This is legal because WB's allowin is always 1.

Decomposition:
- Shared package/defines.vh holds:
  - Bus widths EX_MEM_BUS_W=189, MEM_WB_BUS_W=184, MEM_ID_BUS_W=40.
  - ld_type codes LD_W/LD_B/LD_H/LD_BU/LD_HU.
  - Field offsets of the 184-bit payload.
- One sub-module: mem_load_align (combinational rdata, addr[1:0], ld_type -> 32-bit result).

Test Plan:
- ALU op, no request, wb_allowin=1: result 0x0000_1234 reaches mem_wb_bus final_result one cycle after capture; mem_allowin stays 1.
- ld.b at addr 0x...3, rdata=0x80FF_0011, data_ok 2 cycles late:
  - mem_wb_valid=0 and ld_pending=1 for 2 cycles.
  - Then final_result=0xFFFF_FF80.
  - Repeat as ld.bu: 0x0000_0080.
- ld.h addr[1]=1, rdata=0x7FFF_0000 -> 0x0000_7FFF; ld.hu addr[1]=0, rdata=0x0000_8001 -> 0x0000_8001.
- Flush while a load waits for data_ok:
  - mem_valid cleared and the FSM enters DISCARD.
  - Next data_ok is dropped; the following load receives its own rdata 0xCAFE_F00D correctly.
- Flush in the same cycle as data_ok: no DISCARD entry; the next request's data_ok is accepted.
- MEM_RDATA_BUF_EN with wb_allowin forced 0 during data_ok:
  - rbuf holds the data.
  - mem_wb_bus carries it when wb_allowin rises.
  - A syscall in MEM asserts mem_ex=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: pipeline bus widths, load-type codes,
// field offsets inside the 184-bit EX/MEM payload and the discard FSM states.
package mem_stage_pkg;

  localparam int EX_MEM_BUS_W = 189;
  localparam int MEM_WB_BUS_W = 184;
  localparam int MEM_ID_BUS_W = 40;

  // Load types as encoded by ID; bit 2 selects zero extension.
  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b101;
  localparam logic [2:0] LD_HU = 3'b110;

  // Payload layout (LSB offsets), MSB first:
  // {ertn, gr_we, pc, inst, final_result, dest, csr_we, csr_re,
  //  csr_num, csr_wmask, csr_wvalue, syscall}
  localparam int PL_SYSCALL    = 0;
  localparam int PL_CSR_WVALUE = 1;
  localparam int PL_CSR_WMASK  = 33;
  localparam int PL_CSR_NUM    = 65;
  localparam int PL_CSR_RE     = 79;
  localparam int PL_CSR_WE     = 80;
  localparam int PL_DEST       = 81;
  localparam int PL_RESULT     = 86;
  localparam int PL_INST       = 118;
  localparam int PL_PC         = 150;
  localparam int PL_GR_WE      = 182;
  localparam int PL_ERTN       = 183;

  // Control fields that sit above the payload on the EX/MEM bus.
  localparam int EX_REQ_SENT     = 184;
  localparam int EX_LD_TYPE      = 185;
  localparam int EX_RES_FROM_MEM = 188;

  typedef enum logic {
    DS_IDLE    = 1'b0,
    DS_DISCARD = 1'b1
  } discard_state_e;

  // Extension fill bit: the loaded MSB for signed loads, zero for unsigned.
  function automatic logic ld_fill(input logic msb, input logic [2:0] ld_type);
    return msb & ~ld_type[2];
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the byte/half-word addressed by addr[1:0] out of
// the 32-bit SRAM word and sign- or zero-extends it according to ld_type.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  ld_type,
  output logic [31:0] result
);

  logic [7:0]  byte_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = byte_lane[addr];
  // Half-words are naturally aligned, so addr[0] plays no part.
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  // Select width and extend.
  always_comb begin
    result = rdata;
    case (ld_type)
      LD_B, LD_BU: result = {{24{ld_fill(byte_sel[7], ld_type)}}, byte_sel};
      LD_H, LD_HU: result = {{16{ld_fill(half_sel[15], ld_type)}}, half_sel};
      default:     result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage LoongArch pipeline. Holds one instruction from EX,
// waits for its data-SRAM response, aligns load data and passes the result to
// WB. Exports forwarding/stall info to ID and an exception-pending flag to EX,
// and swallows responses that belong to requests killed by a flush.
// Optional feature: define MEM_RDATA_BUF_EN to add a one-entry response buffer
// so the SRAM need not hold data_ok while WB is stalled.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ex_mem_valid,
  output logic                    mem_allowin,
  input  logic [EX_MEM_BUS_W-1:0] ex_mem_bus,
  input  logic                    wb_allowin,
  output logic                    mem_wb_valid,
  output logic [MEM_WB_BUS_W-1:0] mem_wb_bus,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_ID_BUS_W-1:0] mem_id_bus,
  output logic                    mem_ex,
  input  logic                    flush
);

  logic                    mem_valid_reg;
  logic [EX_MEM_BUS_W-1:0] ex_bus_reg;
  discard_state_e          state_reg;

  logic        res_from_mem;
  logic [2:0]  ld_type;
  logic        mem_req_sent;
  logic [31:0] alu_result;
  logic [4:0]  dest;
  logic        gr_we;
  logic        csr_re;
  logic        syscall;
  logic        ertn;

  logic        discard;
  logic        data_ok_now;
  logic        ready_go;
  logic        rbuf_valid;
  logic [31:0] rdata_sel;
  logic [31:0] load_result;
  logic [31:0] final_result;
  logic        discard_enter;

  assign res_from_mem = ex_bus_reg[EX_RES_FROM_MEM];
  assign ld_type      = ex_bus_reg[EX_LD_TYPE +: 3];
  assign mem_req_sent = ex_bus_reg[EX_REQ_SENT];
  assign alu_result   = ex_bus_reg[PL_RESULT +: 32];
  assign dest         = ex_bus_reg[PL_DEST +: 5];
  assign gr_we        = ex_bus_reg[PL_GR_WE];
  assign csr_re       = ex_bus_reg[PL_CSR_RE];
  assign syscall      = ex_bus_reg[PL_SYSCALL];
  assign ertn         = ex_bus_reg[PL_ERTN];

  // A response seen while discarding belongs to a killed request.
  assign discard     = (state_reg == DS_DISCARD);
  assign data_ok_now = data_sram_data_ok & ~discard;

  assign ready_go     = ~mem_req_sent | data_ok_now | rbuf_valid;
  assign mem_allowin  = ~mem_valid_reg | (ready_go & wb_allowin);
  assign mem_wb_valid = mem_valid_reg & ready_go & ~flush;

`ifdef MEM_RDATA_BUF_EN
  logic        rbuf_valid_reg;
  logic [31:0] rbuf_data_reg;

  // Park a response that arrives while WB is stalled; drop it on hand-off or flush.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rbuf_valid_reg <= 1'b0;
      rbuf_data_reg  <= 32'h0;
    end else if (flush || (mem_wb_valid && wb_allowin)) begin
      rbuf_valid_reg <= 1'b0;
    end else if (mem_valid_reg && mem_req_sent && data_ok_now &&
                 !wb_allowin && !rbuf_valid_reg) begin
      rbuf_valid_reg <= 1'b1;
      rbuf_data_reg  <= data_sram_rdata;
    end
  end

  assign rbuf_valid = rbuf_valid_reg;
  assign rdata_sel  = rbuf_valid_reg ? rbuf_data_reg : data_sram_rdata;
`else
  // Without the buffer the SRAM holds rdata until MEM hands off.
  assign rbuf_valid = 1'b0;
  assign rdata_sel  = data_sram_rdata;
`endif

  mem_load_align u_align (
    .rdata   (rdata_sel),
    .addr    (alu_result[1:0]),
    .ld_type (ld_type),
    .result  (load_result)
  );

  assign final_result = res_from_mem ? load_result : alu_result;

  // Occupancy: a flush kills whatever MEM holds or is about to accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid_reg <= 1'b0;
    end else if (flush) begin
      mem_valid_reg <= 1'b0;
    end else if (mem_allowin) begin
      mem_valid_reg <= ex_mem_valid;
    end
  end

  // Capture the EX bus whenever a new instruction moves in.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ex_bus_reg <= '0;
    end else if (mem_allowin && ex_mem_valid) begin
      ex_bus_reg <= ex_mem_bus;
    end
  end

  // A flush leaves a response outstanding either for the request MEM was
  // waiting on, or for the one EX issued in the same cycle.
  assign discard_enter = flush &
      ((mem_valid_reg & mem_req_sent & ~data_sram_data_ok & ~rbuf_valid) |
       (ex_mem_valid & ex_mem_bus[EX_REQ_SENT] & mem_allowin));

  // Discard FSM: wait for exactly one stale response and swallow it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= DS_IDLE;
    end else begin
      case (state_reg)
        DS_IDLE:    if (discard_enter)     state_reg <= DS_DISCARD;
        DS_DISCARD: if (data_sram_data_ok) state_reg <= DS_IDLE;
        default:                           state_reg <= DS_IDLE;
      endcase
    end
  end

  assign mem_wb_bus = {ex_bus_reg[PL_ERTN:PL_INST], final_result,
                       ex_bus_reg[PL_DEST+4:0]};

  assign mem_id_bus = {mem_valid_reg & gr_we,
                       dest,
                       final_result,
                       mem_valid_reg & res_from_mem & ~ready_go,
                       mem_valid_reg & csr_re};

  assign mem_ex = mem_valid_reg & (syscall | ertn);

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU pass-through, aligned/extended loads
// with late responses, flush while waiting (stale response discard), flush
// coinciding with a response, syscall/ertn/csr flags, reset mid-operation and,
// when MEM_RDATA_BUF_EN is defined, the response buffer under WB back-pressure.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ex_mem_valid;
  logic         mem_allowin;
  logic [188:0] ex_mem_bus;
  logic         wb_allowin;
  logic         mem_wb_valid;
  logic [183:0] mem_wb_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic [39:0]  mem_id_bus;
  logic         mem_ex;
  logic         flush;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] TB_PC = 32'h1c00_1000;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ex_mem_valid      (ex_mem_valid),
    .mem_allowin       (mem_allowin),
    .ex_mem_bus        (ex_mem_bus),
    .wb_allowin        (wb_allowin),
    .mem_wb_valid      (mem_wb_valid),
    .mem_wb_bus        (mem_wb_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_id_bus        (mem_id_bus),
    .mem_ex            (mem_ex),
    .flush             (flush)
  );

  // Field views of the DUT outputs, bit positions taken from the bus layouts.
  wire [31:0] wb_result  = mem_wb_bus[117:86];
  wire [31:0] wb_pc      = mem_wb_bus[181:150];
  wire        fwd_we     = mem_id_bus[39];
  wire [4:0]  fwd_dest   = mem_id_bus[38:34];
  wire [31:0] fwd_data   = mem_id_bus[33:2];
  wire        ld_pending = mem_id_bus[1];
  wire        csr_pend   = mem_id_bus[0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // {res_from_mem, ld_type, req_sent, ertn, gr_we, pc, inst, result, dest,
  //  csr_we, csr_re, csr_num, csr_wmask, csr_wvalue, syscall}
  function automatic logic [188:0] mk_bus(input logic rfm, input logic [2:0] ldt,
      input logic req, input logic [31:0] res, input logic [4:0] dest,
      input logic csr_re, input logic sys, input logic ert);
    return {rfm, ldt, req, ert, 1'b1, TB_PC, 32'h2880_0000, res, dest,
            1'b0, csr_re, 14'h0, 32'h0, 32'h0, sys};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Issue a load, hold off data_ok for 'late' cycles, then return rdata.
  task automatic do_load(input string tag, input logic [2:0] ldt, input logic [31:0] addr,
      input logic [31:0] rdata, input int late, input logic [31:0] exp);
    ex_mem_valid = 1'b1;
    ex_mem_bus   = mk_bus(1'b1, ldt, 1'b1, addr, 5'd9, 1'b0, 1'b0, 1'b0);
    settle();
    check_eq({tag, ".allowin"}, 32'(mem_allowin), 32'd1);
    tick();
    ex_mem_valid = 1'b0;
    for (int i = 0; i < late; i++) begin
      settle();
      check_eq({tag, ".wait_valid"}, 32'(mem_wb_valid), 32'd0);
      check_eq({tag, ".wait_ldpend"}, 32'(ld_pending), 32'd1);
      tick();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    settle();
    check_eq({tag, ".valid"}, 32'(mem_wb_valid), 32'd1);
    check_eq({tag, ".result"}, wb_result, exp);
    check_eq({tag, ".fwd_data"}, fwd_data, exp);
    check_eq({tag, ".ldpend"}, 32'(ld_pending), 32'd0);
    $display("load %s addr=%08h rdata=%08h -> %08h", tag, addr, rdata, wb_result);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn            = 1'b0;
    ex_mem_valid      = 1'b0;
    ex_mem_bus        = '0;
    wb_allowin        = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    flush             = 1'b0;
    repeat (3) tick();
    settle();
    check_eq("rst.valid", 32'(mem_wb_valid), 32'd0);
    check_eq("rst.allowin", 32'(mem_allowin), 32'd1);
    check_eq("rst.mem_ex", 32'(mem_ex), 32'd0);
    check_eq("rst.fwd_we", 32'(fwd_we), 32'd0);
    check_eq("rst.pend", {30'd0, ld_pending, csr_pend}, 32'd0);
    $display("reset released");
    resetn = 1'b1;
    tick();

    // ALU result passes straight through, one cycle after capture.
    ex_mem_valid = 1'b1;
    ex_mem_bus   = mk_bus(1'b0, 3'b000, 1'b0, 32'h0000_1234, 5'd5, 1'b0, 1'b0, 1'b0);
    settle();
    check_eq("alu.allowin0", 32'(mem_allowin), 32'd1);
    tick();
    ex_mem_valid = 1'b0;
    settle();
    check_eq("alu.valid", 32'(mem_wb_valid), 32'd1);
    check_eq("alu.result", wb_result, 32'h0000_1234);
    check_eq("alu.pc", wb_pc, TB_PC);
    check_eq("alu.fwd_we", 32'(fwd_we), 32'd1);
    check_eq("alu.fwd_dest", 32'(fwd_dest), 32'd5);
    check_eq("alu.allowin1", 32'(mem_allowin), 32'd1);
    check_eq("alu.mem_ex", 32'(mem_ex), 32'd0);
    $display("alu result=%08h", wb_result);
    tick();

    do_load("ldb",   3'b001, 32'h0000_1003, 32'h80FF_0011, 2, 32'hFFFF_FF80);
    do_load("ldbu",  3'b101, 32'h0000_1003, 32'h80FF_0011, 2, 32'h0000_0080);
    do_load("ldb2",  3'b001, 32'h0000_1002, 32'h80FF_0011, 0, 32'hFFFF_FFFF);
    do_load("ldh",   3'b010, 32'h0000_2002, 32'h7FFF_0000, 1, 32'h0000_7FFF);
    do_load("ldhu",  3'b110, 32'h0000_2000, 32'h0000_8001, 1, 32'h0000_8001);
    do_load("ldh_s", 3'b010, 32'h0000_2001, 32'h1234_8001, 0, 32'hFFFF_8001);
    do_load("ldw",   3'b000, 32'h0000_2004, 32'h1234_5678, 0, 32'h1234_5678);

    // Flush while a load waits: its late response must be swallowed.
    ex_mem_valid = 1'b1;
    ex_mem_bus   = mk_bus(1'b1, 3'b000, 1'b1, 32'h0000_3000, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    ex_mem_valid = 1'b0;
    tick();
    flush = 1'b1;
    settle();
    check_eq("fl.valid_during", 32'(mem_wb_valid), 32'd0);
    tick();
    flush = 1'b0;
    settle();
    check_eq("fl.allowin", 32'(mem_allowin), 32'd1);
    check_eq("fl.fwd_we", 32'(fwd_we), 32'd0);
    ex_mem_valid = 1'b1;
    ex_mem_bus   = mk_bus(1'b1, 3'b000, 1'b1, 32'h0000_3004, 5'd4, 1'b0, 1'b0, 1'b0);
    tick();
    ex_mem_valid      = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    settle();
    check_eq("fl.stale_dropped", 32'(mem_wb_valid), 32'd0);
    check_eq("fl.stale_ldpend", 32'(ld_pending), 32'd1);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    settle();
    check_eq("fl.wait_own", 32'(mem_wb_valid), 32'd0);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    settle();
    check_eq("fl.own_valid", 32'(mem_wb_valid), 32'd1);
    check_eq("fl.own_result", wb_result, 32'hCAFE_F00D);
    $display("flush-wait: next load result=%08h", wb_result);
    tick();
    data_sram_data_ok = 1'b0;

    // Flush together with the response: no discard, next response accepted.
    ex_mem_valid = 1'b1;
    ex_mem_bus   = mk_bus(1'b1, 3'b000, 1'b1, 32'h0000_4000, 5'd6, 1'b0, 1'b0, 1'b0);
    tick();
    ex_mem_valid = 1'b0;
    tick();
    flush             = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_2222;
    settle();
    check_eq("flok.valid", 32'(mem_wb_valid), 32'd0);
    tick();
    flush             = 1'b0;
    data_sram_data_ok = 1'b0;
    ex_mem_valid      = 1'b1;
    ex_mem_bus        = mk_bus(1'b1, 3'b000, 1'b1, 32'h0000_4004, 5'd6, 1'b0, 1'b0, 1'b0);
    settle();
    check_eq("flok.allowin", 32'(mem_allowin), 32'd1);
    tick();
    ex_mem_valid      = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0BAD_F00D;
    settle();
    check_eq("flok.next_valid", 32'(mem_wb_valid), 32'd1);
    check_eq("flok.next_result", wb_result, 32'h0BAD_F00D);
    $display("flush-with-data_ok: next load result=%08h", wb_result);
    tick();
    data_sram_data_ok = 1'b0;

    // Syscall with csr read, then ertn: exception flag and csr stall.
    ex_mem_valid = 1'b1;
    ex_mem_bus   = mk_bus(1'b0, 3'b000, 1'b0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    ex_mem_bus   = mk_bus(1'b0, 3'b000, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
    settle();
    check_eq("sys.mem_ex", 32'(mem_ex), 32'd1);
    check_eq("sys.csr_pend", 32'(csr_pend), 32'd1);
    $display("syscall mem_ex=%0d", mem_ex);
    tick();
    ex_mem_valid = 1'b0;
    settle();
    check_eq("ertn.mem_ex", 32'(mem_ex), 32'd1);
    check_eq("ertn.csr_pend", 32'(csr_pend), 32'd0);
    $display("ertn mem_ex=%0d", mem_ex);
    tick();
    settle();
    check_eq("idle.mem_ex", 32'(mem_ex), 32'd0);

`ifdef MEM_RDATA_BUF_EN
    // WB stalled when the response arrives: buffered data reaches WB later.
    tick();
    ex_mem_valid = 1'b1;
    ex_mem_bus   = mk_bus(1'b1, 3'b010, 1'b1, 32'h0000_5002, 5'd8, 1'b0, 1'b0, 1'b0);
    tick();
    ex_mem_valid      = 1'b0;
    wb_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hABCD_0000;
    settle();
    check_eq("rbuf.allowin_stall", 32'(mem_allowin), 32'd0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    settle();
    check_eq("rbuf.held_valid", 32'(mem_wb_valid), 32'd1);
    check_eq("rbuf.held_result", wb_result, 32'hFFFF_ABCD);
    tick();
    wb_allowin = 1'b1;
    settle();
    check_eq("rbuf.xfer_result", wb_result, 32'hFFFF_ABCD);
    check_eq("rbuf.xfer_allowin", 32'(mem_allowin), 32'd1);
    $display("rbuf load result=%08h", wb_result);
    tick();
`endif

    // Reset mid-load: state cleared, next response is accepted normally.
    tick();
    ex_mem_valid = 1'b1;
    ex_mem_bus   = mk_bus(1'b1, 3'b000, 1'b1, 32'h0000_6000, 5'd2, 1'b0, 1'b0, 1'b0);
    tick();
    ex_mem_valid = 1'b0;
    resetn       = 1'b0;
    tick();
    resetn = 1'b1;
    settle();
    check_eq("midrst.valid", 32'(mem_wb_valid), 32'd0);
    check_eq("midrst.ldpend", 32'(ld_pending), 32'd0);
    check_eq("midrst.allowin", 32'(mem_allowin), 32'd1);
    $display("reset mid-load");
    tick();
    do_load("post_rst", 3'b000, 32'h0000_6004, 32'h5A5A_A5A5, 1, 32'h5A5A_A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
